// File: rtl/speed_sched.sv
// speed_sched: run/pause/speed controller for the seconds time base.
// Produces a one-cycle tick every (TICK_1X >> speed) cycles while running,
// counts seconds 0..59 and flags the 59->0 wrap with a carry pulse.
module speed_sched #(
    parameter int unsigned TICK_1X = 50_000_000,
    parameter int unsigned PRE_W   = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       speed_up,
    input  logic       speed_dn,
    output logic       tick,
    output logic [5:0] cnt,
    output logic       carry,
    output logic [1:0] speed,
    output logic       running
);

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned SPD_W   = 2;
    localparam int unsigned CNT_MAX = 59;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic               tick_q, tick_d;
    logic               carry_q, carry_d;
    logic               running_q, running_d;

    logic [31:0]        period_c;
    logic [PRE_W-1:0]   pre_last_c;
    logic               spd_chg_c;
    logic               pre_at_last_c;

    // Current period and its terminal prescaler value at the active speed.
    always_comb begin
        period_c      = TICK_1X >> speed_q;
        pre_last_c    = PRE_W'(period_c - 32'd1);
        pre_at_last_c = (pre_q == pre_last_c);
    end

    // Speed index update; simultaneous up/down requests cancel out.
    always_comb begin
        speed_d   = speed_q;
        spd_chg_c = 1'b0;
        if (speed_up && !speed_dn && (speed_q != 2'd3)) begin
            speed_d   = speed_q + 2'd1;
            spd_chg_c = 1'b1;
        end else if (speed_dn && !speed_up && (speed_q != 2'd0)) begin
            speed_d   = speed_q - 2'd1;
            spd_chg_c = 1'b1;
        end
    end

    // Next-state, prescaler, seconds counter and pulse outputs.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;

        if (clr) begin
            state_d = S_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pre_d = '0;
                    cnt_d = '0;
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        // stop wins over a coincident terminal count; pre holds
                        state_d = S_PAUSE;
                    end else if (spd_chg_c) begin
                        pre_d = '0;
                    end else if (pre_at_last_c) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (cnt_q == CNT_W'(CNT_MAX)) begin
                            cnt_d   = '0;
                            carry_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (start) state_d = S_RUN;
                end
                default: begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end
            endcase

            // A speed change restarts the period so pre cannot overshoot it
            if (spd_chg_c) pre_d = '0;
        end

        running_d = (state_d == S_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            speed_q   <= '0;
            tick_q    <= 1'b0;
            carry_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            speed_q   <= speed_d;
            tick_q    <= tick_d;
            carry_q   <= carry_d;
            running_q <= running_d;
        end
    end

    assign tick    = tick_q;
    assign cnt     = cnt_q;
    assign carry   = carry_q;
    assign speed   = speed_q;
    assign running = running_q;

endmodule

// File: tb/tb_speed_sched.sv
// Directed bench for speed_sched with TICK_1X = 16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_speed_sched;

    localparam int unsigned TICK_1X = 16;
    localparam int unsigned PRE_W   = 5;

    // drive() mask bits
    localparam logic [4:0] M_DN    = 5'b00001;
    localparam logic [4:0] M_UP    = 5'b00010;
    localparam logic [4:0] M_START = 5'b00100;
    localparam logic [4:0] M_STOP  = 5'b01000;
    localparam logic [4:0] M_CLR   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clr, speed_up, speed_dn;
    logic       tick, carry, running;
    logic [5:0] cnt;
    logic [1:0] speed;

    int total = 0;
    int bad   = 0;

    speed_sched #(.TICK_1X(TICK_1X), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .speed_up (speed_up),
        .speed_dn (speed_dn),
        .tick     (tick),
        .cnt      (cnt),
        .carry    (carry),
        .speed    (speed),
        .running  (running)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch.
    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Assert the masked inputs for exactly one rising edge (called at a falling edge).
    task automatic drive(input logic [4:0] m);
        {clr, stop, start, speed_up, speed_dn} = m;
        @(negedge clk);
        {clr, stop, start, speed_up, speed_dn} = 5'b0;
    endtask

    // Falling edges until tick is seen; -1 if the budget expires.
    task automatic cycles_to_tick(input int max_c, output int n);
        n = -1;
        for (int i = 1; i <= max_c; i++) begin
            @(negedge clk);
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    // Count ticks over a fixed number of cycles.
    task automatic count_ticks(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tick) n++;
        end
    endtask

    initial begin
        int n;
        int carries;

        rst = 1'b1;
        {clr, stop, start, speed_up, speed_dn} = 5'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset state, first tick latency and steady spacing at 1x
        check_val("rst_tick",    int'(tick),    0);
        check_val("rst_cnt",     int'(cnt),     0);
        check_val("rst_carry",   int'(carry),   0);
        check_val("rst_speed",   int'(speed),   0);
        check_val("rst_running", int'(running), 0);
        count_ticks(20, n);
        check_val("idle_no_tick", n, 0);
        drive(M_START);
        check_val("run_running", int'(running), 1);
        cycles_to_tick(40, n);
        check_val("first_tick_lat", n, 16);
        check_val("first_tick_cnt", int'(cnt), 1);
        check_val("first_tick_carry", int'(carry), 0);
        cycles_to_tick(40, n);
        check_val("tick2_spacing", n, 16);
        check_val("tick2_cnt", int'(cnt), 2);
        @(negedge clk);
        check_val("tick_one_cycle", int'(tick), 0);
        cycles_to_tick(40, n);
        check_val("tick3_spacing", n, 15);
        check_val("tick3_cnt", int'(cnt), 3);

        // 2: run up to 59, then wrap with carry
        carries = 0;
        for (int i = 0; i < 56; i++) begin
            cycles_to_tick(40, n);
            if (n != 16) check_val("run_spacing", n, 16);
            if (carry) carries++;
        end
        check_val("no_early_carry", carries, 0);
        check_val("cnt_59", int'(cnt), 59);
        cycles_to_tick(40, n);
        check_val("wrap_spacing", n, 16);
        check_val("wrap_cnt", int'(cnt), 0);
        check_val("wrap_carry", int'(carry), 1);
        @(negedge clk);
        check_val("carry_one_cycle", int'(carry), 0);
        cycles_to_tick(40, n);
        check_val("post_wrap_spacing", n, 15);
        check_val("post_wrap_carry", int'(carry), 0);
        check_val("post_wrap_cnt", int'(cnt), 1);

        // 3: speed changes restart pre; saturation and cancelling requests
        drive(M_UP);
        check_val("spd1", int'(speed), 1);
        cycles_to_tick(40, n);
        check_val("spd1_lat", n, 8);
        drive(M_UP);
        cycles_to_tick(40, n);
        check_val("spd2_lat", n, 4);
        drive(M_UP);
        cycles_to_tick(40, n);
        check_val("spd3_lat", n, 2);
        drive(M_UP);
        check_val("spd_sat_hi", int'(speed), 3);
        cycles_to_tick(40, n);
        check_val("spd_sat_no_restart", n, 1);
        cycles_to_tick(40, n);
        check_val("spd3_spacing", n, 2);
        drive(M_UP | M_DN);
        check_val("spd_both_ignored", int'(speed), 3);
        cycles_to_tick(40, n);
        check_val("spd_both_lat", n, 1);
        drive(M_DN);
        cycles_to_tick(40, n);
        check_val("dn2_lat", n, 4);
        drive(M_DN);
        cycles_to_tick(40, n);
        check_val("dn1_lat", n, 8);
        drive(M_DN);
        check_val("spd0", int'(speed), 0);
        cycles_to_tick(40, n);
        check_val("dn0_lat", n, 16);
        check_val("cnt_after_speed", int'(cnt), 10);
        drive(M_DN);
        check_val("spd_sat_lo", int'(speed), 0);
        cycles_to_tick(40, n);
        check_val("spd_sat_lo_lat", n, 15);
        check_val("cnt_after_sat_lo", int'(cnt), 11);

        // 4: pause at pre = 9, resume preserves phase
        repeat (9) @(negedge clk);
        drive(M_STOP);
        check_val("pause_running", int'(running), 0);
        count_ticks(100, n);
        check_val("pause_no_tick", n, 0);
        check_val("pause_cnt_hold", int'(cnt), 11);
        drive(M_START);
        check_val("resume_running", int'(running), 1);
        cycles_to_tick(40, n);
        check_val("resume_lat", n, 7);
        check_val("resume_cnt", int'(cnt), 12);

        // 5: stop+start at terminal count: stop wins, no tick
        repeat (15) @(negedge clk);
        drive(M_STOP | M_START);
        check_val("stop_wins_tick", int'(tick), 0);
        check_val("stop_wins_running", int'(running), 0);
        check_val("stop_wins_cnt", int'(cnt), 12);
        drive(M_START);
        cycles_to_tick(40, n);
        check_val("held_last_tick", n, 1);
        check_val("held_last_cnt", int'(cnt), 13);
        drive(M_UP);
        drive(M_CLR | M_START);
        check_val("clr_running", int'(running), 0);
        check_val("clr_cnt", int'(cnt), 0);
        check_val("clr_speed_kept", int'(speed), 1);
        count_ticks(30, n);
        check_val("clr_idle_no_tick", n, 0);

        // 6: async reset mid-period with cnt = 30, speed = 2
        drive(M_UP);
        drive(M_START);
        for (int i = 0; i < 30; i++) begin
            cycles_to_tick(40, n);
            if (n != 4) check_val("spd2_spacing", n, 4);
        end
        check_val("pre_rst_cnt", int'(cnt), 30);
        check_val("pre_rst_speed", int'(speed), 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_cnt", int'(cnt), 0);
        check_val("arst_speed", int'(speed), 0);
        check_val("arst_running", int'(running), 0);
        check_val("arst_tick", int'(tick), 0);
        check_val("arst_carry", int'(carry), 0);
        @(negedge clk);
        rst = 1'b0;
        count_ticks(30, n);
        check_val("post_rst_no_tick", n, 0);
        drive(M_START);
        cycles_to_tick(40, n);
        check_val("post_rst_lat", n, 16);
        check_val("post_rst_cnt", int'(cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
